// File: rtl/alu32_pkg.sv
// alu32_pkg: shared widths, opcode encodings and unit-enable bit positions
// for the 32-bit ALU issue stage and its opcode decoder.
package alu32_pkg;

  localparam int OP_W   = 4;
  localparam int UNIT_N = 9;
  localparam int DATA_W = 32;

  // Opcode encodings; 9..15 are illegal.
  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_NOR = 4'd5;
  localparam logic [OP_W-1:0] OP_SLL = 4'd6;
  localparam logic [OP_W-1:0] OP_SRL = 4'd7;
  localparam logic [OP_W-1:0] OP_SRA = 4'd8;

  // Bit position of each function unit inside the one-hot UnitEn vector.
  localparam int EN_ADD = 0;
  localparam int EN_SUB = 1;
  localparam int EN_AND = 2;
  localparam int EN_OR  = 3;
  localparam int EN_XOR = 4;
  localparam int EN_NOR = 5;
  localparam int EN_SLL = 6;
  localparam int EN_SRL = 7;
  localparam int EN_SRA = 8;

  // True for the three shifter opcodes.
  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu32_op_decode.sv
// alu32_op_decode: combinational opcode decoder on the issue-stage push path.
// Ports:
//   op_i      - 4-bit opcode
//   unit_en_o - one-hot function-unit enable (all zero for illegal opcodes)
//   illegal_o - opcode is outside the defined set
module alu32_op_decode
  import alu32_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  output logic [UNIT_N-1:0] unit_en_o,
  output logic              illegal_o
);

  always_comb begin
    unit_en_o = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD:  unit_en_o[EN_ADD] = 1'b1;
      OP_SUB:  unit_en_o[EN_SUB] = 1'b1;
      OP_AND:  unit_en_o[EN_AND] = 1'b1;
      OP_OR:   unit_en_o[EN_OR]  = 1'b1;
      OP_XOR:  unit_en_o[EN_XOR] = 1'b1;
      OP_NOR:  unit_en_o[EN_NOR] = 1'b1;
      OP_SLL:  unit_en_o[EN_SLL] = 1'b1;
      OP_SRL:  unit_en_o[EN_SRL] = 1'b1;
      OP_SRA:  unit_en_o[EN_SRA] = 1'b1;
      default: illegal_o         = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu32_issue_stage.sv
// alu32_issue_stage: registered issue FIFO feeding the 32-bit ALU function
// units. Ops arrive over a valid/ready handshake, are pre-decoded to a
// one-hot unit enable, tagged with a wrapping sequence number and held at the
// head with stable operands until the consumer accepts.
//
// Ports:
//   Clk, Rst_n          - clock (rising edge), async active-low reset
//   InValid/InReady     - upstream handshake; InReady depends only on count
//   InA, InB, InOp      - operands and opcode (shift amount is InB[4:0])
//   OutValid/OutReady   - downstream handshake for the head entry
//   Op1, Op2            - head operands (zero when OutValid=0)
//   UnitEn              - head one-hot unit enable (zero when empty/illegal)
//   OutTag              - head sequence tag
//   ErrIllegal          - head opcode is illegal
//   ShamtOvf            - head shift amount exceeds 31
//
// Optional feature macro: ALU32_ISSUE_SHAMT_CHK_EN. When undefined, ShamtOvf
// is tied low and no per-entry overflow flag is stored.
//
// DEPTH must be a power of two and >= 2 so the pointers wrap naturally.
module alu32_issue_stage
  import alu32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       InA,
  input  logic [31:0]       InB,
  input  logic [3:0]        InOp,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [31:0]       Op1,
  output logic [31:0]       Op2,
  output logic [8:0]        UnitEn,
  output logic [TAG_W-1:0]  OutTag,
  output logic              ErrIllegal,
  output logic              ShamtOvf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [TAG_W-1:0] tag_q,    tag_d;

  // Entry storage; contents are only observable through the OutValid gate,
  // so it needs no reset.
  logic [DEPTH-1:0][DATA_W-1:0] mem_a_q;
  logic [DEPTH-1:0][DATA_W-1:0] mem_b_q;
  logic [DEPTH-1:0][UNIT_N-1:0] mem_en_q;
  logic [DEPTH-1:0]             mem_ill_q;
  logic [DEPTH-1:0][TAG_W-1:0]  mem_tag_q;

  logic [UNIT_N-1:0] dec_en;
  logic              dec_ill;
  logic              push, pop;

  alu32_op_decode u_dec (
    .op_i      (InOp),
    .unit_en_o (dec_en),
    .illegal_o (dec_ill)
  );

  assign InReady  = (count_q < CNT_W'(DEPTH));
  assign OutValid = (count_q != '0);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tag_d    = tag_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      tag_d    = tag_q + TAG_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_q    <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tag_q    <= tag_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]   <= InA;
      mem_b_q[wr_ptr_q]   <= InB;
      mem_en_q[wr_ptr_q]  <= dec_en;
      mem_ill_q[wr_ptr_q] <= dec_ill;
      mem_tag_q[wr_ptr_q] <= tag_q;
    end
  end

  // Gate everything with OutValid so idle units see all-zero inputs.
  assign Op1        = OutValid ? mem_a_q[rd_ptr_q]   : '0;
  assign Op2        = OutValid ? mem_b_q[rd_ptr_q]   : '0;
  assign UnitEn     = OutValid ? mem_en_q[rd_ptr_q]  : '0;
  assign OutTag     = OutValid ? mem_tag_q[rd_ptr_q] : '0;
  assign ErrIllegal = OutValid & mem_ill_q[rd_ptr_q];

`ifdef ALU32_ISSUE_SHAMT_CHK_EN
  logic [DEPTH-1:0] mem_ovf_q;
  logic             push_ovf;

  // Shift amount only uses InB[4:0]; any higher bit set means overflow.
  assign push_ovf = is_shift(InOp) && (InB[DATA_W-1:5] != '0);

  always_ff @(posedge Clk) begin
    if (push) mem_ovf_q[wr_ptr_q] <= push_ovf;
  end

  assign ShamtOvf = OutValid & mem_ovf_q[rd_ptr_q];
`else
  assign ShamtOvf = 1'b0;
`endif

endmodule

// File: doc/alu32_issue_stage.md
Name: alu32_issue_stage

Overview:
- Registered issue stage directly upstream of the 32-bit ALU function units, including the gate-level logical right shifter.
- Accepts (A, B, opcode) operations over a valid/ready handshake and buffers them in a small FIFO.
- Drives stable operands plus a one-hot unit-enable vector until the downstream consumer accepts.
- Each accepted operation gets a sequence tag for result matching.

Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2.
- TAG_W, 4, width of the sequence tag counter.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- InValid  in  1  upstream op present.
- InReady  out  1  stage can accept an op.
- InA  in  32  operand 1.
- InB  in  32  operand 2; shift amount is InB[4:0] for shift ops.
- InOp  in  4  opcode.
- OutValid  out  1  head op presented.
- OutReady  in  1  downstream accepts head.
- Op1  out  32  head operand 1, feeds unit In1.
- Op2  out  32  head operand 2, feeds unit In2.
- UnitEn  out  9  one-hot unit enable, feeds each unit's Enable.
- OutTag  out  TAG_W  sequence tag of head.
- ErrIllegal  out  1  head opcode is illegal.
- ShamtOvf  out  1  optional, see Optional Feature.

Behaviour:
- Reset (async assert, sync release): count=0, read/write pointers=0, tag counter=0.
  - Outputs at reset: InReady=1, OutValid=0, Op1=0, Op2=0, UnitEn=0, OutTag=0, ErrIllegal=0, ShamtOvf=0.
  - Reset mid-operation discards all buffered ops.
- Opcodes and UnitEn bit index:
  - 0 ADD→bit0, 1 SUB→bit1, 2 AND→bit2, 3 OR→bit3, 4 XOR→bit4, 5 NOR→bit5, 6 SLL→bit6, 7 SRL→bit7, 8 SRA→bit8.
  - 9–15 are illegal.
- Push occurs when InValid && InReady:
  - the entry stores InA, InB, the pre-decoded 9-bit one-hot, the illegal flag and the current tag;
  - the tag increments modulo 2^TAG_W and wraps.
- Pop occurs when OutValid && OutReady.
- InReady = (count < DEPTH), derived combinationally from registered count. It does not depend on OutReady, so there is no same-cycle pass-through when full.
- OutValid = (count != 0).
- Latency: an op pushed at edge N is visible on the outputs after edge N, when the FIFO was empty.
- Output gating:
  - when OutValid=0, Op1/Op2/UnitEn/OutTag/ErrIllegal/ShamtOvf read 0, so every shifter output stays 0;
  - when OutValid=1, they reflect the head entry and stay stable until popped.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Full (count=DEPTH): no push is possible; a pop alone frees one slot for the next cycle.
  - Empty: no pop occurs.
- Illegal opcode: the op is accepted and gets a tag; UnitEn=0 and ErrIllegal=1 while it is at head; it pops normally.
- Pointers wrap modulo DEPTH.
- Upstream must hold InA/InB/InOp while InValid && !InReady. The stage does not check this.

Optional Feature:
- Macro: ALU32_ISSUE_SHAMT_CHK_EN.
- Defined: at push, the flag (op ∈ {SLL, SRL, SRA}) && (InB[31:5] != 0) is stored; ShamtOvf outputs it for the head entry (gated by OutValid).
- Undefined: ShamtOvf is tied to 0 and no per-entry flag storage exists.

Decomposition:
- Package alu32_pkg:
  - OP_W=4, UNIT_N=9, DATA_W=32;
  - opcode constants OP_ADD…OP_SRA;
  - UnitEn bit-index constants.
- Sub-module alu32_op_decode: combinational 4-bit opcode → 9-bit one-hot plus illegal flag; instantiated on the push path.

Test Plan:
- Reset: hold Rst_n=0 mid-stream with 2 ops buffered, release → OutValid=0, UnitEn=0, InReady=1, next accepted op carries tag 0.
- Single SRL: push A=0x80000000, B=5, op=7 with OutReady=0 → next cycle OutValid=1, UnitEn=0x080, Op1=0x80000000, Op2=5, OutTag=0; values stable for 3 cycles until OutReady=1.
- Full/backpressure: OutReady=0, push 3 ops → first two accepted, InReady=0 after the second; third held; raise OutReady for 1 cycle → third accepted next cycle, count stays 2.
- Stream: InValid=1 and OutReady=1 continuously for 20 ops → one op per cycle, tags 0..15 then wrap to 0..3, order preserved.
- Illegal: push op=12 → UnitEn=0, ErrIllegal=1, tag consumed; the following ADD shows UnitEn=0x001, ErrIllegal=0.
- With ALU32_ISSUE_SHAMT_CHK_EN: SRL with B=0x00000021 → ShamtOvf=1; AND with the same B → ShamtOvf=0.
